// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - registered N-channel mux with manual select and round-robin scan
//
// Purpose:
//   Picks one of CHANNELS W-bit inputs and presents it registered. The output is
//   tagged with the source channel index and carries a one-cycle strobe on the
//   first sample of each newly selected channel. MANUAL mode selects via
//   sel/sel_load. SCAN mode rotates 0..CHANNELS-1 and holds each channel for
//   dwell+1 cycles.
//
// Build option:
//   MUX_SCAN_SEL_SCAN_EN - when defined, the SCAN state, the dwell counter and the
//   mode/dwell inputs are functional. When undefined, the block is permanently
//   MANUAL and mode/dwell are ignored.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   di        packed inputs, channel k = di[k*WIDTH +: WIDTH]
//   sel       manual channel index
//   sel_load  capture sel into the select register (MANUAL only)
//   mode      0 = MANUAL, 1 = SCAN
//   dwell     extra hold cycles per channel in SCAN
//   do_data   registered selected data (0 when the index is out of range)
//   do_sel    channel index that do_data came from
//   do_valid  strobe on the first sample of a newly selected or reloaded channel
//   sel_err   do_sel >= CHANNELS
module mux_scan_sel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] di,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          do_data,
  output logic [SEL_W-1:0]          do_sel,
  output logic                      do_valid,
  output logic                      sel_err
);

  // One extra bit so CHANNELS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] prev_sel;
  logic             reload_q;
  logic             reload_d;
  logic             in_range;
  logic [WIDTH-1:0] mux;

  assign in_range = ({1'b0, sel_q} < NCH);

  // Out-of-range indices match no channel and fall through to zero.
  always_comb begin
    mux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_q == k[SEL_W-1:0]) begin
        mux = di[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUX_SCAN_SEL_SCAN_EN
  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic [SEL_W:0] LAST = (SEL_W+1)'(CHANNELS-1);

  state_t             state_q;
  state_t             state_d;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MANUAL;
      dwell_cnt <= '0;
    end else begin
      state_q   <= state_d;
      dwell_cnt <= dwell_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dwell_cnt_d = '0;
    reload_d    = 1'b0;
    case (state_q)
      MANUAL: begin
        // Scan entry takes priority over a simultaneous manual load.
        if (mode) begin
          state_d  = SCAN;
          sel_d    = '0;
          reload_d = 1'b1;
        end else if (sel_load) begin
          sel_d    = sel;
          reload_d = 1'b1;
        end
      end
      SCAN: begin
        if (!mode) begin
          state_d = MANUAL;
        end else if (dwell_cnt >= dwell) begin
          // Live dwell compare: shrinking dwell mid-hold advances at once.
          sel_d = ({1'b0, sel_q} >= LAST) ? '0 : sel_q + 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt + 1'b1;
        end
      end
      default: state_d = MANUAL;
    endcase
  end
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{mode, dwell};

  always_comb begin
    sel_d    = sel_q;
    reload_d = 1'b0;
    if (sel_load) begin
      sel_d    = sel;
      reload_d = 1'b1;
    end
  end
`endif

  // prev_sel trails sel_q by one cycle. When the output stage consumes sel_q,
  // comparing against prev_sel detects a change made on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      prev_sel <= '0;
      reload_q <= 1'b0;
      do_data  <= '0;
      do_sel   <= '0;
      do_valid <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      prev_sel <= sel_q;
      reload_q <= reload_d;
      do_data  <= in_range ? mux : '0;
      do_sel   <= sel_q;
      sel_err  <= ~in_range;
      do_valid <= reload_q | (sel_q != prev_sel);
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// tb/tb_mux_scan_sel.sv - scoreboard bench for mux_scan_sel
module tb_mux_scan_sel;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8*W-1:0] di8;
  logic [6*W-1:0] di6;
  logic [SW-1:0]  sel;
  logic           sel_load, sel_load6, mode, mode6;
  logic [DW-1:0]  dwell;
  logic [W-1:0]   do8, do6;
  logic [SW-1:0]  ds8, ds6;
  logic           dv8, dv6, se8, se6;

  mux_scan_sel #(.WIDTH(W), .CHANNELS(8), .SEL_W(SW), .DWELL_W(DW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .di(di8), .sel(sel), .sel_load(sel_load),
    .mode(mode), .dwell(dwell), .do_data(do8), .do_sel(ds8),
    .do_valid(dv8), .sel_err(se8)
  );

  mux_scan_sel #(.WIDTH(W), .CHANNELS(6), .SEL_W(SW), .DWELL_W(DW)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .di(di6), .sel(sel), .sel_load(sel_load6),
    .mode(mode6), .dwell(dwell), .do_data(do6), .do_sel(ds6),
    .do_valid(dv6), .sel_err(se6)
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          e;
    int            c;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  exp_t x8, x6;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c, n, m0, exp_pre;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push8(input logic [W-1:0] d, input logic [SW-1:0] s, input logic e, input int at);
    exp_t x;
    x.d = d; x.s = s; x.e = e; x.c = at;
    q8.push_back(x);
  endtask

  task automatic push6(input logic [W-1:0] d, input logic [SW-1:0] s, input logic e, input int at);
    exp_t x;
    x.d = d; x.s = s; x.e = e; x.c = at;
    q6.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n && dv8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL dut8 unexpected strobe cyc=%0d do=%h sel=%0d", cyc, do8, ds8);
      end else begin
        x8 = q8.pop_front();
        if (do8 !== x8.d || ds8 !== x8.s || se8 !== x8.e || cyc != x8.c) begin
          errors++;
          $display("FAIL dut8 strobe got do=%h sel=%0d err=%b cyc=%0d expected do=%h sel=%0d err=%b cyc=%0d",
                   do8, ds8, se8, cyc, x8.d, x8.s, x8.e, x8.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && dv6) begin
      checks++;
      if (q6.size() == 0) begin
        errors++;
        $display("FAIL dut6 unexpected strobe cyc=%0d do=%h sel=%0d", cyc, do6, ds6);
      end else begin
        x6 = q6.pop_front();
        if (do6 !== x6.d || ds6 !== x6.s || se6 !== x6.e || cyc != x6.c) begin
          errors++;
          $display("FAIL dut6 strobe got do=%h sel=%0d err=%b cyc=%0d expected do=%h sel=%0d err=%b cyc=%0d",
                   do6, ds6, se6, cyc, x6.d, x6.s, x6.e, x6.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    di8 = '0;
    di6 = '0;
    for (int k = 0; k < 8; k++) di8[k*W +: W] = W'(16 + k);
    for (int k = 0; k < 6; k++) di6[k*W +: W] = W'(16 + k);
    sel = '0; sel_load = 1'b0; sel_load6 = 1'b0;
    mode = 1'b0; mode6 = 1'b0; dwell = '0;

    repeat (3) step();
    chk("reset do8", 32'(do8), 32'h0);
    chk("reset do_sel8", 32'(ds8), 32'h0);
    chk("reset do_valid8", 32'(dv8), 32'h0);
    chk("reset sel_err8", 32'(se8), 32'h0);
    chk("reset do6", 32'(do6), 32'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // Manual load of channel 5.
    c = cyc; sel = 3'd5; sel_load = 1'b1;
    push8(8'h15, 3'd5, 1'b0, c + 2);
    step(); sel_load = 1'b0;
    repeat (3) step();

    // Data path latency: one edge from di to do.
    di8[5*W +: W] = 8'hA5;
    step();
    chk("data latency", 32'(do8), 32'hA5);
    di8[5*W +: W] = 8'h15;
    step();

    // Out-of-range select on the six-channel instance, then back in range.
    c = cyc; sel = 3'd7; sel_load6 = 1'b1;
    push6(8'h00, 3'd7, 1'b1, c + 2);
    step(); sel_load6 = 1'b0;
    repeat (3) step();
    chk("sel_err held", 32'(se6), 32'h1);
    c = cyc; sel = 3'd2; sel_load6 = 1'b1;
    push6(8'h12, 3'd2, 1'b0, c + 2);
    step(); sel_load6 = 1'b0;
    repeat (2) step();
    c = cyc; sel_load6 = 1'b1;
    push6(8'h12, 3'd2, 1'b0, c + 2);
    step(); sel_load6 = 1'b0;
    repeat (3) step();
    chk("sel_err cleared", 32'(se6), 32'h0);

`ifdef MUX_SCAN_SEL_SCAN_EN
    // Scan with dwell=2: three cycles per channel, wrap after 24.
    dwell = 4'd2; n = cyc; mode = 1'b1;
    for (int j = 0; j < 8; j++) push8(W'(16 + j), SW'(j), 1'b0, n + 2 + 3*j);
    // Dwell=0 from the wrap onward: one cycle per channel.
    for (int j = 0; j < 10; j++) push8(W'(16 + j % 8), SW'(j % 8), 1'b0, n + 26 + j);
    // Dwell=3 taken while the counter is 0: channel 1 is held four cycles.
    push8(8'h12, 3'd2, 1'b0, n + 39);
    push8(8'h13, 3'd3, 1'b0, n + 43);
    push8(8'h14, 3'd4, 1'b0, n + 47);
    wait_cyc(n + 25); dwell = 4'd0;
    wait_cyc(n + 34); dwell = 4'd3;
    wait_cyc(n + 47); mode = 1'b0;
    repeat (8) step();
    chk("manual hold do_sel", 32'(ds8), 32'h4);
    chk("manual hold do", 32'(do8), 32'h14);
    c = cyc; sel = 3'd4; sel_load = 1'b1;
    push8(8'h14, 3'd4, 1'b0, c + 2);
    step(); sel_load = 1'b0;
    repeat (4) step();

    // Re-enter scan and reset mid-hold of channel 1.
    m0 = cyc; mode = 1'b1;
    push8(8'h10, 3'd0, 1'b0, m0 + 2);
    push8(8'h11, 3'd1, 1'b0, m0 + 6);
    wait_cyc(m0 + 7);
    exp_pre = 1;
`else
    dwell = 4'd2; mode = 1'b1;
    repeat (10) step();
    chk("mode ignored do_sel", 32'(ds8), 32'h5);
    c = cyc; sel = 3'd4; sel_load = 1'b1;
    push8(8'h14, 3'd4, 1'b0, c + 2);
    step(); sel_load = 1'b0;
    repeat (4) step();
    exp_pre = 4;
`endif
    #3;
    chk("pre-reset do_sel", 32'(ds8), 32'(exp_pre));
    rst_n = 1'b0;
    #1;
    chk("async reset do", 32'(do8), 32'h0);
    chk("async reset do_sel", 32'(ds8), 32'h0);
    chk("async reset do_valid", 32'(dv8), 32'h0);
    chk("async reset sel_err", 32'(se8), 32'h0);
    mode = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post-reset do_sel", 32'(ds8), 32'h0);
    chk("post-reset do", 32'(do8), 32'h10);
    chk("post-reset do6", 32'(do6), 32'h10);
    repeat (5) step();
    chk("manual after reset", 32'(ds8), 32'h0);

    checks++;
    if (q8.size() != 0 || q6.size() != 0) begin
      errors++;
      $display("FAIL missing strobes dut8=%0d dut6=%0d expected 0", q8.size(), q6.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
